// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types, default 640x480@60 timing and width helper for the VGA generator
//
// Contents:
//   mode_e         test-pattern selector (black, solid, colour bars, checkerboard)
//   vga_timing_t   one complete set of horizontal/vertical mode timings
//   VGA_640X480_60 default timing constants
//   clog2          counter width for a given total count (never below 1)
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_BLACK = 2'd0,
        MODE_SOLID = 2'd1,
        MODE_BARS  = 2'd2,
        MODE_CHECK = 2'd3
    } mode_e;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
    };

    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - video output bundle of the VGA timing generator
//
// Signals:
//   red/green/blue  colour channels, COLOR_W bits each
//   hsync/vsync     sync pulses at the configured polarity
//   de              display enable (active area)
//   x/y             pixel column / line of the current output
//   frame_start     one-tick pulse aligned with pixel (0,0)
// Modports: master (generator drives), slave (display sink reads).
interface vga_timing_gen_if #(
    parameter int COLOR_W = 4,
    parameter int X_W     = 10,
    parameter int Y_W     = 10
);
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
    logic               hsync;
    logic               vsync;
    logic               de;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic               frame_start;

    modport master (
        output red, green, blue, hsync, vsync, de, x, y, frame_start
    );

    modport slave (
        input red, green, blue, hsync, vsync, de, x, y, frame_start
    );
endinterface

// File: rtl/vga_pattern.sv
// rtl/vga_pattern.sv - registered test-pattern colour stage
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   ce               pixel clock-enable; colour holds when low
//   x                current pixel column (counter value, not yet registered)
//   y_bit            bit CHECK_LOG2 of the current line, selects checker row phase
//   de               active-area flag for the same pixel
//   mode, color      pattern select and solid colour latched at frame start
//   red/green/blue   registered colour, aligned with the other registered outputs
module vga_pattern
    import vga_pkg::*;
#(
    parameter int COLOR_W    = 4,
    parameter int X_W        = 10,
    parameter int H_ACTIVE   = 640,
    parameter int CHECK_LOG2 = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic [X_W-1:0]       x,
    input  logic                 y_bit,
    input  logic                 de,
    input  mode_e                mode,
    input  logic [3*COLOR_W-1:0] color,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue
);
    localparam int BAR_W = H_ACTIVE / 8;

    generate
        if ((H_ACTIVE % 8) != 0) begin : g_bad_h_active
            $error("vga_pattern: H_ACTIVE must be divisible by 8");
        end
    endgenerate

    logic [2:0]           bar;
    logic [3*COLOR_W-1:0] rgb_next;

    // Bar 0 is black and bar 7 white; the index bits map straight onto R/G/B.
    assign bar = 3'(int'(x) / BAR_W);

    always_comb begin
        rgb_next = '0;
        if (de) begin
            case (mode)
                MODE_SOLID: rgb_next = color;
                MODE_BARS:  rgb_next = {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}};
                MODE_CHECK: rgb_next = {(3*COLOR_W){x[CHECK_LOG2] ^ y_bit}};
                default:    rgb_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (ce) begin
            {red, green, blue} <= rgb_next;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing and test-pattern generator
//
// Ports:
//   clk_i      pixel or system clock
//   reset_ni   asynchronous active-low reset
//   px_ce_i    pixel clock-enable (tie high when clk_i is the pixel clock)
//   mode_i     pattern select, latched at each (0,0) wrap
//   color_i    solid colour {R,G,B}, latched with mode_i
//   vid        video output bundle (master side)
// All outputs are registered one pixel tick behind the h/v counters.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_640X480_60.h_active,
    parameter int H_FP       = VGA_640X480_60.h_fp,
    parameter int H_SYNC     = VGA_640X480_60.h_sync,
    parameter int H_BP       = VGA_640X480_60.h_bp,
    parameter int V_ACTIVE   = VGA_640X480_60.v_active,
    parameter int V_FP       = VGA_640X480_60.v_fp,
    parameter int V_SYNC     = VGA_640X480_60.v_sync,
    parameter int V_BP       = VGA_640X480_60.v_bp,
    parameter int H_POL      = 0,
    parameter int V_POL      = 0,
    parameter int COLOR_W    = 4,
    parameter int CHECK_LOG2 = 5
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 px_ce_i,
    input  logic [1:0]           mode_i,
    input  logic [3*COLOR_W-1:0] color_i,
    vga_timing_gen_if.master     vid
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int X_W      = clog2(H_TOTAL);
    localparam int Y_W      = clog2(V_TOTAL);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam logic HS_ON  = 1'(H_POL);
    localparam logic VS_ON  = 1'(V_POL);

    logic [X_W-1:0]       h_cnt;
    logic [Y_W-1:0]       v_cnt;
    mode_e                mode_q;
    logic [3*COLOR_W-1:0] color_q;
    logic                 h_last;
    logic                 v_last;
    logic                 de_next;
    logic                 hs_next;
    logic                 vs_next;

    assign h_last  = (h_cnt == X_W'(H_TOTAL - 1));
    assign v_last  = (v_cnt == Y_W'(V_TOTAL - 1));
    assign de_next = (h_cnt < X_W'(H_ACTIVE)) && (v_cnt < Y_W'(V_ACTIVE));
    assign hs_next = (h_cnt >= X_W'(HS_START)) && (h_cnt < X_W'(HS_END));
    assign vs_next = (v_cnt >= Y_W'(VS_START)) && (v_cnt < Y_W'(VS_END));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            h_cnt           <= '0;
            v_cnt           <= '0;
            mode_q          <= MODE_BLACK;
            color_q         <= '0;
            vid.hsync       <= ~HS_ON;
            vid.vsync       <= ~VS_ON;
            vid.de          <= 1'b0;
            vid.x           <= '0;
            vid.y           <= '0;
            vid.frame_start <= 1'b0;
        end else if (px_ce_i) begin
            h_cnt <= h_last ? '0 : h_cnt + 1'b1;
            if (h_last) begin
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end
            // Capture the pattern only on the frame wrap so a frame is never torn.
            if (h_last && v_last) begin
                mode_q  <= mode_e'(mode_i);
                color_q <= color_i;
            end
            vid.hsync       <= hs_next ? HS_ON : ~HS_ON;
            vid.vsync       <= vs_next ? VS_ON : ~VS_ON;
            vid.de          <= de_next;
            vid.x           <= h_cnt;
            vid.y           <= v_cnt;
            vid.frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end else begin
            // The strobe lasts one clk_i cycle even when the pixel rate is slower.
            vid.frame_start <= 1'b0;
        end
    end

    vga_pattern #(
        .COLOR_W    (COLOR_W),
        .X_W        (X_W),
        .H_ACTIVE   (H_ACTIVE),
        .CHECK_LOG2 (CHECK_LOG2)
    ) u_pattern (
        .clk   (clk_i),
        .rst_n (reset_ni),
        .ce    (px_ce_i),
        .x     (h_cnt),
        .y_bit (v_cnt[CHECK_LOG2]),
        .de    (de_next),
        .mode  (mode_q),
        .color (color_q),
        .red   (vid.red),
        .green (vid.green),
        .blue  (vid.blue)
    );
endmodule
